// File: rtl/alu_arb_pkg.sv
// Shared constants for the ALU sharing arbiter: opcodes, requester IDs and FSM encoding.
package alu_arb_pkg;

  localparam logic [4:0] OPC_ADD = 5'b00000;
  localparam logic [4:0] OPC_SUB = 5'b00001;
  localparam logic [4:0] OPC_AND = 5'b00010;
  localparam logic [4:0] OPC_OR  = 5'b00011;
  localparam logic [4:0] OPC_SLL = 5'b00100;
  localparam logic [4:0] OPC_SRA = 5'b00101;

  localparam logic RID_EXEC = 1'b0;
  localparam logic RID_BR   = 1'b1;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } arb_state_e;

endpackage

// File: rtl/alu.sv
// Processor ALU: add/sub/and/or/sll/sra with isNotEqual/isLessThan taken from A-B
// and overflow reported for add and sub only.
module alu
  import alu_arb_pkg::*;
(
  input  logic [31:0] data_operandA,
  input  logic [31:0] data_operandB,
  input  logic [4:0]  ctrl_ALUopcode,
  input  logic [4:0]  ctrl_shiftamt,
  output logic [31:0] data_result,
  output logic        isNotEqual,
  output logic        isLessThan,
  output logic        overflow
);

  logic [31:0] sum_s;
  logic [31:0] diff_s;
  logic        add_ovf_s;
  logic        sub_ovf_s;

  always_comb begin
    sum_s     = data_operandA + data_operandB;
    diff_s    = data_operandA - data_operandB;
    add_ovf_s = (data_operandA[31] == data_operandB[31]) && (sum_s[31] != data_operandA[31]);
    sub_ovf_s = (data_operandA[31] != data_operandB[31]) && (diff_s[31] != data_operandA[31]);
    // Signed less-than: sign of the difference corrected by subtract overflow
    isNotEqual = |diff_s;
    isLessThan = diff_s[31] ^ sub_ovf_s;

    data_result = 32'h0000_0000;
    overflow    = 1'b0;
    case (ctrl_ALUopcode)
      OPC_ADD: begin
        data_result = sum_s;
        overflow    = add_ovf_s;
      end
      OPC_SUB: begin
        data_result = diff_s;
        overflow    = sub_ovf_s;
      end
      OPC_AND: data_result = data_operandA & data_operandB;
      OPC_OR:  data_result = data_operandA | data_operandB;
      OPC_SLL: data_result = data_operandA << ctrl_shiftamt;
      OPC_SRA: data_result = $signed(data_operandA) >>> ctrl_shiftamt;
      default: begin
        data_result = 32'h0000_0000;
        overflow    = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one ALU between execute (req0) and branch-compare (req1) with a single-entry
// registered response. Define ALU_ARB_FIXED_PRIO_EN to make requester 0 always win contention.
module alu_share_arbiter
  import alu_arb_pkg::*;
#(
  parameter int DW  = 32,
  parameter int OPW = 5
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           req0_valid,
  output logic           req0_ready,
  input  logic [OPW-1:0] req0_opcode,
  input  logic [OPW-1:0] req0_shamt,
  input  logic [DW-1:0]  req0_a,
  input  logic [DW-1:0]  req0_b,
  input  logic           req1_valid,
  output logic           req1_ready,
  input  logic [OPW-1:0] req1_opcode,
  input  logic [OPW-1:0] req1_shamt,
  input  logic [DW-1:0]  req1_a,
  input  logic [DW-1:0]  req1_b,
  output logic           rsp0_valid,
  input  logic           rsp0_ready,
  output logic           rsp1_valid,
  input  logic           rsp1_ready,
  output logic [DW-1:0]  rsp_result,
  output logic           rsp_ne,
  output logic           rsp_lt,
  output logic           rsp_ovf
);

  arb_state_e     state_q, state_d;
  logic           rsp_id_q, rsp_id_d;
  logic [DW-1:0]  result_q;
  logic           ne_q, lt_q, ovf_q;

  logic           consume_s;
  logic           can_accept_s;
  logic           sel_s;
  logic           accept_s;
  logic [DW-1:0]  alu_a_s, alu_b_s, alu_res_s;
  logic [OPW-1:0] alu_op_s, alu_sh_s;
  logic           alu_ne_s, alu_lt_s, alu_ovf_s;

`ifndef ALU_ARB_FIXED_PRIO_EN
  logic           last_grant_q;
`endif

  always_comb begin
    if (state_q == HOLD) begin
      consume_s = (rsp_id_q == RID_BR) ? rsp1_ready : rsp0_ready;
    end else begin
      consume_s = 1'b0;
    end
    // The single output slot frees up in the same cycle its response is taken
    can_accept_s = (state_q == IDLE) | consume_s;

`ifdef ALU_ARB_FIXED_PRIO_EN
    sel_s = req0_valid ? RID_EXEC : RID_BR;
`else
    if (req0_valid && req1_valid) begin
      sel_s = ~last_grant_q;
    end else begin
      sel_s = req0_valid ? RID_EXEC : RID_BR;
    end
`endif

    req0_ready = can_accept_s & req0_valid & (sel_s == RID_EXEC);
    req1_ready = can_accept_s & req1_valid & (sel_s == RID_BR);
    accept_s   = req0_ready | req1_ready;

    alu_a_s  = (sel_s == RID_BR) ? req1_a      : req0_a;
    alu_b_s  = (sel_s == RID_BR) ? req1_b      : req0_b;
    alu_op_s = (sel_s == RID_BR) ? req1_opcode : req0_opcode;
    alu_sh_s = (sel_s == RID_BR) ? req1_shamt  : req0_shamt;
  end

  alu u_alu (
    .data_operandA  (alu_a_s),
    .data_operandB  (alu_b_s),
    .ctrl_ALUopcode (alu_op_s),
    .ctrl_shiftamt  (alu_sh_s),
    .data_result    (alu_res_s),
    .isNotEqual     (alu_ne_s),
    .isLessThan     (alu_lt_s),
    .overflow       (alu_ovf_s)
  );

  always_comb begin
    state_d  = state_q;
    rsp_id_d = rsp_id_q;
    if (accept_s) begin
      state_d  = HOLD;
      rsp_id_d = sel_s;
    end else if (consume_s) begin
      state_d  = IDLE;
    end else begin
      state_d  = state_q;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      rsp_id_q     <= RID_EXEC;
      result_q     <= '0;
      ne_q         <= 1'b0;
      lt_q         <= 1'b0;
      ovf_q        <= 1'b0;
`ifndef ALU_ARB_FIXED_PRIO_EN
      last_grant_q <= RID_BR;
`endif
    end else begin
      state_q  <= state_d;
      rsp_id_q <= rsp_id_d;
      if (accept_s) begin
        result_q     <= alu_res_s;
        ne_q         <= alu_ne_s;
        lt_q         <= alu_lt_s;
        ovf_q        <= alu_ovf_s;
`ifndef ALU_ARB_FIXED_PRIO_EN
        last_grant_q <= sel_s;
`endif
      end
    end
  end

  always_comb begin
    rsp0_valid = (state_q == HOLD) & (rsp_id_q == RID_EXEC);
    rsp1_valid = (state_q == HOLD) & (rsp_id_q == RID_BR);
    rsp_result = result_q;
    rsp_ne     = ne_q;
    rsp_lt     = lt_q;
    rsp_ovf    = ovf_q;
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed, table-driven bench for alu_share_arbiter plus multi-cycle handshake sequences.
module tb_alu_share_arbiter;
  import alu_arb_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [4:0]  req0_opcode, req0_shamt, req1_opcode, req1_shamt;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic        rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
  logic [31:0] rsp_result;
  logic        rsp_ne, rsp_lt, rsp_ovf;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        rid;
    logic [4:0]  opc;
    logic [4:0]  sh;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        ne;
    logic        lt;
    logic        ovf;
  } vec_t;

  vec_t vecs[8];

  always #5 clock = ~clock;

  alu_share_arbiter #(.DW(32), .OPW(5)) dut (
    .clock(clock), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_opcode(req0_opcode),
    .req0_shamt(req0_shamt), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_opcode(req1_opcode),
    .req1_shamt(req1_shamt), .req1_a(req1_a), .req1_b(req1_b),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp_result(rsp_result), .rsp_ne(rsp_ne), .rsp_lt(rsp_lt), .rsp_ovf(rsp_ovf)
  );

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_req0(input logic v, input logic [4:0] op, input logic [4:0] sh,
                          input logic [31:0] a, input logic [31:0] b);
    req0_valid = v; req0_opcode = op; req0_shamt = sh; req0_a = a; req0_b = b;
  endtask

  task automatic set_req1(input logic v, input logic [4:0] op, input logic [4:0] sh,
                          input logic [31:0] a, input logic [31:0] b);
    req1_valid = v; req1_opcode = op; req1_shamt = sh; req1_a = a; req1_b = b;
  endtask

  initial begin
    logic g_exp;
    logic g_prev;

    vecs[0] = '{1'b0, OPC_ADD, 5'd0,  32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b1, 1'b0, 1'b1};
    vecs[1] = '{1'b1, OPC_SUB, 5'd0,  32'h0000_0003, 32'h0000_0009, 32'hFFFF_FFFA, 1'b1, 1'b1, 1'b0};
    vecs[2] = '{1'b0, OPC_SUB, 5'd0,  32'h0000_000A, 32'h0000_000A, 32'h0000_0000, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{1'b1, OPC_SUB, 5'd0,  32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b1};
    vecs[4] = '{1'b0, OPC_AND, 5'd0,  32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h00F0_00F0, 1'b1, 1'b1, 1'b0};
    vecs[5] = '{1'b1, OPC_OR,  5'd0,  32'h1234_0000, 32'h0000_5678, 32'h1234_5678, 1'b1, 1'b0, 1'b0};
    vecs[6] = '{1'b0, OPC_SLL, 5'd31, 32'h0000_0001, 32'h0000_0000, 32'h8000_0000, 1'b1, 1'b0, 1'b0};
    vecs[7] = '{1'b1, OPC_SRA, 5'd4,  32'h8000_0000, 32'h0000_0000, 32'hF800_0000, 1'b1, 1'b1, 1'b0};

    reset = 1'b1;
    set_req0(1'b0, OPC_ADD, 5'd0, 32'd0, 32'd0);
    set_req1(1'b0, OPC_ADD, 5'd0, 32'd0, 32'd0);
    rsp0_ready = 1'b0;
    rsp1_ready = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b0;

    chk1("rst_rsp0_valid", rsp0_valid, 1'b0);
    chk1("rst_rsp1_valid", rsp1_valid, 1'b0);
    chk32("rst_result", rsp_result, 32'h0);
    chk1("rst_ne", rsp_ne, 1'b0);
    chk1("rst_lt", rsp_lt, 1'b0);
    chk1("rst_ovf", rsp_ovf, 1'b0);
    chk1("rst_idle_rdy0", req0_ready, 1'b0);

    // Reset while a response is held
    set_req0(1'b1, OPC_ADD, 5'd0, 32'd5, 32'd7);
    #1 chk1("rsthold_accept", req0_ready, 1'b1);
    @(negedge clock);
    req0_valid = 1'b0;
    chk1("rsthold_valid", rsp0_valid, 1'b1);
    chk32("rsthold_result", rsp_result, 32'd12);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    chk1("rsthold_drop0", rsp0_valid, 1'b0);
    chk1("rsthold_drop1", rsp1_valid, 1'b0);
    chk32("rsthold_result0", rsp_result, 32'h0);

    // Continuous contention, both responses always consumed
    set_req0(1'b1, OPC_ADD, 5'd0, 32'd100, 32'd1);
    set_req1(1'b1, OPC_SUB, 5'd0, 32'd100, 32'd1);
    rsp0_ready = 1'b1;
    rsp1_ready = 1'b1;
    g_prev = 1'b0;
    for (int k = 0; k < 6; k++) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
      g_exp = 1'b0;
`else
      g_exp = k[0];
`endif
      #1;
      chk1("rr_rdy0", req0_ready, ~g_exp);
      chk1("rr_rdy1", req1_ready, g_exp);
      if (k > 0) begin
        chk1("rr_rsp0", rsp0_valid, ~g_prev);
        chk1("rr_rsp1", rsp1_valid, g_prev);
        chk32("rr_result", rsp_result, g_prev ? 32'd99 : 32'd101);
      end
      g_prev = g_exp;
      @(negedge clock);
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    chk1("rr_last_rsp1", rsp1_valid, g_prev);
    chk32("rr_last_result", rsp_result, g_prev ? 32'd99 : 32'd101);
    @(negedge clock);
    chk1("rr_idle0", rsp0_valid, 1'b0);
    chk1("rr_idle1", rsp1_valid, 1'b0);
    rsp0_ready = 1'b0;
    rsp1_ready = 1'b0;

    // Single-requester operation table
    for (int i = 0; i < 8; i++) begin
      if (vecs[i].rid == RID_BR) set_req1(1'b1, vecs[i].opc, vecs[i].sh, vecs[i].a, vecs[i].b);
      else                       set_req0(1'b1, vecs[i].opc, vecs[i].sh, vecs[i].a, vecs[i].b);
      #1;
      chk1($sformatf("vec%0d_rdy0", i), req0_ready, ~vecs[i].rid);
      chk1($sformatf("vec%0d_rdy1", i), req1_ready, vecs[i].rid);
      @(negedge clock);
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      chk1($sformatf("vec%0d_rsp0", i), rsp0_valid, ~vecs[i].rid);
      chk1($sformatf("vec%0d_rsp1", i), rsp1_valid, vecs[i].rid);
      chk32($sformatf("vec%0d_result", i), rsp_result, vecs[i].res);
      chk1($sformatf("vec%0d_ne", i), rsp_ne, vecs[i].ne);
      chk1($sformatf("vec%0d_lt", i), rsp_lt, vecs[i].lt);
      chk1($sformatf("vec%0d_ovf", i), rsp_ovf, vecs[i].ovf);
      if (vecs[i].rid == RID_BR) rsp1_ready = 1'b1;
      else                       rsp0_ready = 1'b1;
      @(negedge clock);
      rsp0_ready = 1'b0;
      rsp1_ready = 1'b0;
      chk1($sformatf("vec%0d_done0", i), rsp0_valid, 1'b0);
      chk1($sformatf("vec%0d_done1", i), rsp1_valid, 1'b0);
    end

    // Backpressure on rsp0, then back-to-back handoff to req1
    set_req0(1'b1, OPC_ADD, 5'd0, 32'd2, 32'd3);
    @(negedge clock);
    req0_valid = 1'b0;
    set_req1(1'b1, OPC_SUB, 5'd0, 32'd20, 32'd5);
    for (int j = 0; j < 3; j++) begin
      #1;
      chk1("bp_rdy0", req0_ready, 1'b0);
      chk1("bp_rdy1", req1_ready, 1'b0);
      chk1("bp_rsp0", rsp0_valid, 1'b1);
      chk32("bp_result", rsp_result, 32'd5);
      @(negedge clock);
    end
    rsp0_ready = 1'b1;
    #1 chk1("bp_handoff_rdy1", req1_ready, 1'b1);
    @(negedge clock);
    rsp0_ready = 1'b0;
    req1_valid = 1'b0;
    chk1("bp_next_rsp1", rsp1_valid, 1'b1);
    chk1("bp_next_rsp0", rsp0_valid, 1'b0);
    chk32("bp_next_result", rsp_result, 32'd15);
    rsp1_ready = 1'b1;
    @(negedge clock);
    rsp1_ready = 1'b0;
    chk1("bp_done1", rsp1_valid, 1'b0);

    // Payload held by req1 while the slot is occupied
    set_req0(1'b1, OPC_ADD, 5'd0, 32'd1, 32'd1);
    @(negedge clock);
    req0_valid = 1'b0;
    set_req1(1'b1, OPC_SUB, 5'd0, 32'd10, 32'd10);
    #1 chk1("ph_wait_rdy1", req1_ready, 1'b0);
    @(negedge clock);
    chk32("ph_held_result", rsp_result, 32'd2);
    rsp0_ready = 1'b1;
    #1 chk1("ph_grant_rdy1", req1_ready, 1'b1);
    @(negedge clock);
    rsp0_ready = 1'b0;
    req1_valid = 1'b0;
    chk1("ph_rsp1", rsp1_valid, 1'b1);
    chk32("ph_result", rsp_result, 32'd0);
    chk1("ph_ne", rsp_ne, 1'b0);
    chk1("ph_lt", rsp_lt, 1'b0);
    rsp1_ready = 1'b1;
    @(negedge clock);
    rsp1_ready = 1'b0;
    chk1("ph_nodup1", rsp1_valid, 1'b0);
    @(negedge clock);
    chk1("ph_nodup1_b", rsp1_valid, 1'b0);
    chk1("ph_nodup0", rsp0_valid, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
